paced_updown_counter: RTL

//  Generation-2 rate-divided display counter. Merges the prescaler and the

---
 rtl/paced_updown_counter.sv | 96 +++++++++
 1 files changed

// File: rtl/paced_updown_counter.sv
// Rate-divided up/down display counter with built-in prescaler.
// Supports parallel load, run/pause, and wrap or saturate at the end value.
module paced_updown_counter #(
   parameter int CLOCK_FREQUENCY = 500,
   parameter int WIDTH           = 4,
   parameter int SPEED_BITS      = 2
) (
   input  logic                  ClockIn,
   input  logic                  Reset,
   input  logic [SPEED_BITS-1:0] Speed,
   input  logic                  Run,
   input  logic                  Up,
   input  logic                  Mode,
   input  logic                  Load,
   input  logic [WIDTH-1:0]      LoadValue,
   output logic [WIDTH-1:0]      CounterValue,
   output logic                  Tick,
   output logic                  Wrapped,
   output logic                  AtEnd
);

   localparam int NSPD = 2 ** SPEED_BITS;
   localparam longint PMAX = longint'(CLOCK_FREQUENCY) << (NSPD - 2);
   localparam int PW = (PMAX > 1) ? $clog2(PMAX) : 1;
   localparam logic [PW:0] CF_W = (PW + 1)'(CLOCK_FREQUENCY);
   localparam logic [WIDTH-1:0] CV_MAX = '1;

   logic [PW-1:0]         pc_q, pc_d, pc_last;
   logic [PW:0]           period, per_m1;
   logic [SPEED_BITS-1:0] spd_q, spd_d;
   logic [WIDTH-1:0]      cv_q, cv_d;
   logic                  wr_q, wr_d;
   logic                  spd_chg, at_end;

   // Last prescaler value of the period selected by the live Speed input
   always_comb begin
      period = (PW + 1)'(1);
      if (Speed != '0) begin
         period = CF_W << (Speed - SPEED_BITS'(1));
      end
      per_m1  = period - (PW + 1)'(1);
      pc_last = per_m1[PW-1:0];
   end

   assign spd_chg = (Speed != spd_q);
   assign at_end  = (cv_q == (Up ? CV_MAX : '0));
   assign Tick    = Run & (pc_q == pc_last) & ~Load & ~Reset & ~spd_chg;

   // Next state: load, then speed change, then step or prescaler advance
   always_comb begin
      pc_d  = pc_q;
      cv_d  = cv_q;
      spd_d = spd_q;
      wr_d  = 1'b0;
      if (Load) begin
         cv_d  = LoadValue;
         pc_d  = '0;
         spd_d = Speed;
      end else if (spd_chg) begin
         pc_d  = '0;
         spd_d = Speed;
      end else if (Tick) begin
         pc_d = '0;
         if (at_end) begin
            if (!Mode) begin
               cv_d = Up ? '0 : CV_MAX;
               wr_d = 1'b1;
            end
         end else begin
            cv_d = Up ? cv_q + WIDTH'(1) : cv_q - WIDTH'(1);
         end
      end else if (Run) begin
         pc_d = pc_q + PW'(1);
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         pc_q  <= '0;
         cv_q  <= '0;
         wr_q  <= 1'b0;
         spd_q <= Speed;
      end else begin
         pc_q  <= pc_d;
         cv_q  <= cv_d;
         wr_q  <= wr_d;
         spd_q <= spd_d;
      end
   end

   assign CounterValue = cv_q;
   assign Wrapped      = wr_q;
   assign AtEnd        = at_end;

endmodule
